// File: rtl/ibex_rvfi_trace_buffer.sv
// ibex_rvfi_trace_buffer
//   Captures one compact record per RVFI retirement into a flop-based
//   circular buffer and presents the oldest record to a valid/ready consumer.
//   Capture can freeze on the first trapping instruction so that the history
//   leading up to the trap is preserved until the host clears it.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   enable_i              capture enable (ignored retirements are not drops)
//   clear_i               synchronous flush of pointers, counters and freeze
//   rvfi_*_i              retirement record from the core
//   trace_valid_o/ready_i head record handshake
//   trace_*_o             head record fields (zero while empty)
//   count_o               occupancy 0..Depth
//   drop_cnt_o            saturating count of lost records
//   frozen_o              capture stopped by a trap
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth      = 16,
    parameter bit          StopOnFull = 1'b0,
    parameter bit          TrapFreeze = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     rvfi_valid_i,
    input  logic                     rvfi_trap_i,
    input  logic                     rvfi_intr_i,
    input  logic [1:0]               rvfi_mode_i,
    input  logic [31:0]              rvfi_pc_rdata_i,
    input  logic [31:0]              rvfi_insn_i,
    input  logic [4:0]               rvfi_rd_addr_i,
    input  logic [31:0]              rvfi_rd_wdata_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [31:0]              trace_pc_o,
    output logic [31:0]              trace_insn_o,
    output logic [4:0]               trace_rd_addr_o,
    output logic [31:0]              trace_rd_wdata_o,
    output logic [3:0]               trace_flags_o,
    output logic [15:0]              trace_seq_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     frozen_o
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

    typedef struct packed {
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [15:0] seq;
    } rec_t;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_e;

    rec_t          mem [Depth];
    rec_t          wr_rec;
    rec_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   seq;
    logic [15:0]   drop_cnt;
    state_e        state;
    state_e        state_nxt;

    logic full;
    logic valid;
    logic cap;
    logic pop;
    logic drop;
    logic wr_en;
    logic rd_adv;

    assign full  = (count == FULL_CNT);
    assign valid = (count != '0);
    assign cap   = rvfi_valid_i & enable_i & (state == RUN);
    assign pop   = valid & trace_ready_i;
    // Full with no pop this cycle: record is lost either way (incoming or oldest).
    assign drop  = cap & full & ~pop;
    assign wr_en = cap & ~(drop & StopOnFull);
    // Overwrite mode pushes the head forward when the oldest entry is replaced.
    assign rd_adv = pop | (drop & ~StopOnFull);

    assign wr_rec = '{trap:     rvfi_trap_i,
                      intr:     rvfi_intr_i,
                      mode:     rvfi_mode_i,
                      pc:       rvfi_pc_rdata_i,
                      insn:     rvfi_insn_i,
                      rd_addr:  rvfi_rd_addr_i,
                      rd_wdata: rvfi_rd_wdata_i,
                      seq:      seq};

    // Storage has no reset; outputs are masked by valid instead.
    always_ff @(posedge clk_i) begin
        if (wr_en && !clear_i) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            seq      <= '0;
            drop_cnt <= '0;
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            seq      <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
                seq    <= seq + 16'd1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Overwrite (wr_en & rd_adv) keeps occupancy at Depth.
            if (wr_en && !rd_adv) begin
                count <= count + CW'(1);
            end else if (!wr_en && rd_adv) begin
                count <= count - CW'(1);
            end
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Freeze FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Freeze FSM: next state
    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = RUN;
        end else if (state == RUN && cap && rvfi_trap_i && TrapFreeze) begin
            state_nxt = FROZEN;
        end
    end

    // Freeze FSM: outputs
    always_comb begin
        frozen_o = (state == FROZEN);
    end

    assign head = valid ? mem[rd_ptr] : '0;

    assign trace_valid_o    = valid;
    assign trace_pc_o       = head.pc;
    assign trace_insn_o     = head.insn;
    assign trace_rd_addr_o  = head.rd_addr;
    assign trace_rd_wdata_o = head.rd_wdata;
    assign trace_flags_o    = {head.trap, head.intr, head.mode};
    assign trace_seq_o      = head.seq;
    assign count_o          = count;
    assign drop_cnt_o       = drop_cnt;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Bench for ibex_rvfi_trace_buffer: two instances (overwrite and stop-on-full)
// share one stimulus stream and are compared every cycle against a queue model.
module tb_ibex_rvfi_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [3:0]  flags;
        logic [15:0] seq;
    } mrec_t;

    logic clk = 1'b0;
    logic rst, enable, clear, rv_valid, rv_trap, rv_intr, ready;
    logic [1:0]  rv_mode;
    logic [31:0] rv_pc, rv_insn, rv_wd;
    logic [4:0]  rv_rd;

    logic        o_valid [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_insn  [2];
    logic [4:0]  o_rd    [2];
    logic [31:0] o_wd    [2];
    logic [3:0]  o_flags [2];
    logic [15:0] o_seq   [2];
    logic [4:0]  o_count [2];
    logic [15:0] o_drop  [2];
    logic        o_froz  [2];

    // reference model state, index 0 = overwrite, 1 = stop-on-full
    mrec_t       mq [2][$];
    logic [15:0] mseq  [2];
    int          mdrop [2];
    logic        mfroz [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ibex_rvfi_trace_buffer #(.Depth(DEPTH), .StopOnFull(1'b0), .TrapFreeze(1'b1)) u_ovw (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .rvfi_valid_i(rv_valid), .rvfi_trap_i(rv_trap), .rvfi_intr_i(rv_intr),
        .rvfi_mode_i(rv_mode), .rvfi_pc_rdata_i(rv_pc), .rvfi_insn_i(rv_insn),
        .rvfi_rd_addr_i(rv_rd), .rvfi_rd_wdata_i(rv_wd),
        .trace_valid_o(o_valid[0]), .trace_ready_i(ready),
        .trace_pc_o(o_pc[0]), .trace_insn_o(o_insn[0]), .trace_rd_addr_o(o_rd[0]),
        .trace_rd_wdata_o(o_wd[0]), .trace_flags_o(o_flags[0]), .trace_seq_o(o_seq[0]),
        .count_o(o_count[0]), .drop_cnt_o(o_drop[0]), .frozen_o(o_froz[0])
    );

    ibex_rvfi_trace_buffer #(.Depth(DEPTH), .StopOnFull(1'b1), .TrapFreeze(1'b1)) u_sof (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .rvfi_valid_i(rv_valid), .rvfi_trap_i(rv_trap), .rvfi_intr_i(rv_intr),
        .rvfi_mode_i(rv_mode), .rvfi_pc_rdata_i(rv_pc), .rvfi_insn_i(rv_insn),
        .rvfi_rd_addr_i(rv_rd), .rvfi_rd_wdata_i(rv_wd),
        .trace_valid_o(o_valid[1]), .trace_ready_i(ready),
        .trace_pc_o(o_pc[1]), .trace_insn_o(o_insn[1]), .trace_rd_addr_o(o_rd[1]),
        .trace_rd_wdata_o(o_wd[1]), .trace_flags_o(o_flags[1]), .trace_seq_o(o_seq[1]),
        .count_o(o_count[1]), .drop_cnt_o(o_drop[1]), .frozen_o(o_froz[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mseq[m]  = '0;
            mdrop[m] = 0;
            mfroz[m] = 1'b0;
        end
    endtask

    // One clock edge of the model, from the inputs held across that edge.
    task automatic model_step();
        mrec_t r;
        bit    cap;
        for (int m = 0; m < 2; m++) begin
            if (clear) begin
                mq[m].delete();
                mseq[m]  = '0;
                mdrop[m] = 0;
                mfroz[m] = 1'b0;
                continue;
            end
            cap = rv_valid && enable && !mfroz[m];
            if (mq[m].size() > 0 && ready) void'(mq[m].pop_front());
            if (cap) begin
                r.pc = rv_pc; r.insn = rv_insn; r.rd = rv_rd; r.wd = rv_wd;
                r.flags = {rv_trap, rv_intr, rv_mode}; r.seq = mseq[m];
                if (mq[m].size() == DEPTH) begin
                    if (mdrop[m] < 65535) mdrop[m]++;
                    if (m == 0) begin
                        void'(mq[m].pop_front());
                        mq[m].push_back(r);
                        mseq[m]++;
                    end
                end else begin
                    mq[m].push_back(r);
                    mseq[m]++;
                end
                if (rv_trap) mfroz[m] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        mrec_t e;
        for (int m = 0; m < 2; m++) begin
            if (mq[m].size() > 0) e = mq[m][0];
            else begin
                e.pc = '0; e.insn = '0; e.rd = '0; e.wd = '0; e.flags = '0; e.seq = '0;
            end
            chk($sformatf("m%0d valid", m), 64'(o_valid[m]), 64'(mq[m].size() > 0));
            chk($sformatf("m%0d pc", m),    64'(o_pc[m]),    64'(e.pc));
            chk($sformatf("m%0d insn", m),  64'(o_insn[m]),  64'(e.insn));
            chk($sformatf("m%0d rd", m),    64'(o_rd[m]),    64'(e.rd));
            chk($sformatf("m%0d wdata", m), 64'(o_wd[m]),    64'(e.wd));
            chk($sformatf("m%0d flags", m), 64'(o_flags[m]), 64'(e.flags));
            chk($sformatf("m%0d seq", m),   64'(o_seq[m]),   64'(e.seq));
            chk($sformatf("m%0d count", m), 64'(o_count[m]), 64'(mq[m].size()));
            chk($sformatf("m%0d drop", m),  64'(o_drop[m]),  64'(mdrop[m]));
            chk($sformatf("m%0d frozen", m), 64'(o_froz[m]), 64'(mfroz[m]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic retire(input logic [31:0] pc, input logic trap);
        rv_valid = 1'b1;
        rv_trap  = trap;
        rv_pc    = pc;
        rv_insn  = $urandom;
        rv_rd    = 5'($urandom);
        rv_wd    = $urandom;
        rv_intr  = 1'($urandom);
        rv_mode  = 2'($urandom);
    endtask

    task automatic do_clear();
        rv_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; clear = 1'b0; ready = 1'b0;
        rv_valid = 1'b0; rv_trap = 1'b0; rv_intr = 1'b0; rv_mode = '0;
        rv_pc = '0; rv_insn = '0; rv_rd = '0; rv_wd = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        tick();
        chk("reset count", 64'(o_count[0]), 64'd0);

        // three retirements held, then drained in order
        for (int i = 0; i < 3; i++) begin
            retire(32'h100 + 32'(4 * i), 1'b0);
            tick();
        end
        rv_valid = 1'b0;
        chk("t1 count", 64'(o_count[0]), 64'd3);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1 head pc", 64'(o_pc[0]), 64'(32'h100 + 32'(4 * i)));
            chk("t1 head seq", 64'(o_seq[0]), 64'(i));
            tick();
        end
        chk("t1 empty", 64'(o_valid[0]), 64'd0);

        // 20 retirements into a 16-deep buffer, no draining
        ready = 1'b0;
        do_clear();
        for (int i = 0; i < 20; i++) begin
            retire(32'h1000 + 32'(4 * i), 1'b0);
            tick();
        end
        rv_valid = 1'b0;
        chk("t2 ovw count", 64'(o_count[0]), 64'd16);
        chk("t2 ovw drop", 64'(o_drop[0]), 64'd4);
        chk("t2 ovw head seq", 64'(o_seq[0]), 64'd4);
        chk("t3 sof count", 64'(o_count[1]), 64'd16);
        chk("t3 sof drop", 64'(o_drop[1]), 64'd4);
        chk("t3 sof head seq", 64'(o_seq[1]), 64'd0);
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3 sof drain seq", 64'(o_seq[1]), 64'(i));
            chk("t2 ovw drain seq", 64'(o_seq[0]), 64'(4 + i));
            tick();
        end

        // full buffer with simultaneous capture and pop
        ready = 1'b0;
        do_clear();
        for (int i = 0; i < 16; i++) begin
            retire($urandom, 1'b0);
            tick();
        end
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            retire($urandom, 1'b0);
            tick();
        end
        rv_valid = 1'b0; ready = 1'b0;
        chk("t5 ovw count", 64'(o_count[0]), 64'd16);
        chk("t5 ovw drop", 64'(o_drop[0]), 64'd0);
        chk("t5 sof count", 64'(o_count[1]), 64'd16);
        chk("t5 sof drop", 64'(o_drop[1]), 64'd0);

        // trap freezes capture with the trapping record kept
        do_clear();
        retire(32'h200, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            retire(32'h300 + 32'(4 * i), 1'b0);
            tick();
        end
        rv_valid = 1'b0;
        chk("t4 frozen", 64'(o_froz[0]), 64'd1);
        chk("t4 count", 64'(o_count[0]), 64'd1);
        chk("t4 pc", 64'(o_pc[0]), 64'h200);
        chk("t4 trap flag", 64'(o_flags[0][3]), 64'd1);
        do_clear();
        chk("t4 clr count", 64'(o_count[0]), 64'd0);
        chk("t4 clr frozen", 64'(o_froz[0]), 64'd0);

        // capture disabled, then reset while holding records
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            retire($urandom, 1'b0);
            tick();
        end
        chk("t6 dis count", 64'(o_count[0]), 64'd0);
        chk("t6 dis drop", 64'(o_drop[0]), 64'd0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            retire($urandom, 1'b0);
            tick();
        end
        rv_valid = 1'b0;
        chk("t6 count", 64'(o_count[0]), 64'd5);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        chk("t6 rst valid", 64'(o_valid[0]), 64'd0);
        chk("t6 rst pc", 64'(o_pc[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // randomized traffic with varying drain pressure
        for (int blk = 0; blk < 15; blk++) begin
            int rdy_pct = $urandom_range(0, 100);
            int vld_pct = $urandom_range(20, 100);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 99) < vld_pct) retire($urandom, ($urandom_range(0, 39) == 0));
                else rv_valid = 1'b0;
                ready  = ($urandom_range(0, 99) < rdy_pct);
                enable = ($urandom_range(0, 19) != 0);
                clear  = ($urandom_range(0, 99) == 0);
                tick();
            end
        end
        clear = 1'b0; rv_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
